d_cache_2way_param: RTL and testbench
=====================================

D_CACHE_2WAY_PARAM -- requirements
Module: d_cache_2way_param

Interface
REQ-001 The block SHALL have parameter NUM_SETS, default 4, number of sets (power of 2, 2..64); INDEX_W = log2(NUM_SETS), TAG_W = 28 - INDEX_W.
REQ-002 The block SHALL have these ports, one per line:
  clk  input  1  clock, all state on rising edge
  rst_n  input  1  reset, synchronous, active-low
  DCACHE_ren  input  1  processor word read request
  DCACHE_wen  input  1  processor word write request
  DCACHE_addr  input  30  word address; [1:0] word offset, [INDEX_W+1:2] set, [29:INDEX_W+2] tag
  DCACHE_wdata  input  32  write data
  DCACHE_stall  output  1  processor must hold request
  DCACHE_rdata  output  32  read data, valid when ren=1 and stall=0
  mem_read_D  output  1  block read request
  mem_write_D  output  1  block write request
  mem_addr_D  output  28  block address
  mem_wdata_D  output  128  write-back block
  mem_rdata_D  input  128  fill block, word0 in [31:0]
  mem_ready_D  input  1  memory completes current request

Function
REQ-003 The block SHALL be 2-way set-associative, 4 words/line, write-back, write-allocate; per line valid, dirty, tag; one LRU bit per set naming the victim way.
REQ-004 The block SHALL use states IDLE, WRITEBACK, ALLOCATE.
REQ-005 In IDLE with ren or wen, hit (valid and tag equal in either way) SHALL give stall=0 in the same cycle; read hit drives rdata combinationally from the selected word.
REQ-006 A write hit SHALL update the addressed word and set dirty=1 at the next clock edge.
REQ-007 Every hit SHALL set the set's LRU bit to the other way at the clock edge.
REQ-008 With ren=wen=1 the block SHALL treat the access as a write; ren=wen=0 SHALL give stall=0 with no state change.
REQ-009 Victim selection on miss SHALL be: invalid way0, else invalid way1, else way named by LRU; victim way latched on leaving IDLE.
REQ-010 Miss with dirty victim SHALL go IDLE->WRITEBACK; clean or invalid victim SHALL go IDLE->ALLOCATE.
REQ-011 WRITEBACK SHALL drive mem_write_D=1, mem_addr_D={victim tag, set}, mem_wdata_D=victim data, held stable until mem_ready_D sampled high, then clear victim dirty and go to ALLOCATE.
REQ-012 ALLOCATE SHALL drive mem_read_D=1, mem_addr_D=DCACHE_addr[29:2], held until mem_ready_D sampled high; at that edge write mem_rdata_D into victim way, valid=1, dirty=0, new tag; go to IDLE.
REQ-013 The access SHALL then complete as a hit in IDLE (next cycle), including LRU update and, for writes, merge of DCACHE_wdata.
REQ-014 DCACHE_stall SHALL be 1 in WRITEBACK and ALLOCATE and on an IDLE miss; 0 otherwise.
REQ-015 mem_read_D and mem_write_D SHALL never be 1 simultaneously; both 0 in IDLE; mem_ready_D in IDLE ignored.
REQ-016 mem_wdata_D SHALL be 0 outside WRITEBACK; mem_addr_D SHALL be DCACHE_addr[29:2] outside WRITEBACK.

Reset
REQ-017 rst_n=0 at a clock edge SHALL force state IDLE and clear all valid, dirty and LRU bits; data/tag arrays need not reset.
REQ-018 While rst_n=0: stall=0, mem_read_D=0, mem_write_D=0, rdata=0, mem_addr_D=0, mem_wdata_D=0.
REQ-019 Reset during WRITEBACK/ALLOCATE SHALL abandon the transfer; the pending access misses again after reset.

Configuration
REQ-020 With DCACHE_PERF_CNT_EN defined the block SHALL add outputs hit_cnt[31:0] and miss_cnt[31:0], reset to 0, wrapping at 2^32.
REQ-021 miss_cnt SHALL increment once per IDLE->WRITEBACK/ALLOCATE transition; hit_cnt once per completing hit not preceded by a refill of the same access.
REQ-022 Without DCACHE_PERF_CNT_EN these ports and counters SHALL not exist; all other behaviour identical.

Verification (NUM_SETS=4)
REQ-023 Cold read addr 30'h10 -> stall=1, mem_read_D=1, mem_addr_D=28'h4; ready with rdata {A3,A2,A1,A0} -> next cycle stall=0, DCACHE_rdata=32'hA0.
REQ-024 Then write 30'h11 data 32'hDEADBEEF -> stall=0, no mem request; read 30'h11 -> 32'hDEADBEEF.
REQ-025 Fill 30'h20 (clean), re-read 30'h20, read 30'h30 -> evicts dirty 30'h10 line: mem_write_D=1, mem_addr_D=28'h4, mem_wdata_D[63:32]=32'hDEADBEEF, then mem_read_D with mem_addr_D=28'hC.
REQ-026 Read 30'h20 then 30'h30 (30'h10 clean, older) -> no mem_write_D, mem_read_D only with 28'hC.
REQ-027 rst_n=0 during ALLOCATE for 30'h10 -> next edge mem_read_D=0; after release read 30'h10 misses again with mem_addr_D=28'h4.
REQ-028 With DCACHE_PERF_CNT_EN: REQ-023 then REQ-024 -> miss_cnt=1, hit_cnt=2.

Source files
------------

// File: rtl/d_cache_2way_param.sv
// d_cache_2way_param: 2-way set-associative, write-back, write-allocate data
// cache with 4 words per line and one LRU bit per set. A miss optionally
// writes back a dirty victim, then refills the line; the access then completes
// as an ordinary hit on the following IDLE cycle.
// Optional feature: define DCACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt
// performance counter outputs.
module d_cache_2way_param #(
    parameter int NUM_SETS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         DCACHE_ren,
    input  logic         DCACHE_wen,
    input  logic [29:0]  DCACHE_addr,
    input  logic [31:0]  DCACHE_wdata,
    output logic         DCACHE_stall,
    output logic [31:0]  DCACHE_rdata,
    output logic         mem_read_D,
    output logic         mem_write_D,
    output logic [27:0]  mem_addr_D,
    output logic [127:0] mem_wdata_D,
    input  logic [127:0] mem_rdata_D,
    input  logic         mem_ready_D
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);

    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int TAG_W   = 28 - INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t state_q, state_d;
    logic   victim_q, victim_d;

    logic               valid_q [2][NUM_SETS];
    logic               dirty_q [2][NUM_SETS];
    logic               lru_q   [NUM_SETS];
    logic [TAG_W-1:0]   tag_q   [2][NUM_SETS];
    logic [127:0]       data_q  [2][NUM_SETS];

    logic [INDEX_W-1:0] set_idx;
    logic [TAG_W-1:0]   addr_tag;
    logic [1:0]         word_off;
    logic               req, hit0, hit1, hit, hit_way, victim_sel;
    logic               hit_done, wb_done, fill_done;
    logic [127:0]       hit_line;

    assign set_idx    = DCACHE_addr[INDEX_W+1:2];
    assign addr_tag   = DCACHE_addr[29:INDEX_W+2];
    assign word_off   = DCACHE_addr[1:0];
    assign req        = DCACHE_ren | DCACHE_wen;
    assign hit0       = valid_q[0][set_idx] && (tag_q[0][set_idx] == addr_tag);
    assign hit1       = valid_q[1][set_idx] && (tag_q[1][set_idx] == addr_tag);
    assign hit        = hit0 | hit1;
    assign hit_way    = hit1 & ~hit0;
    assign victim_sel = !valid_q[0][set_idx] ? 1'b0 :
                        (!valid_q[1][set_idx] ? 1'b1 : lru_q[set_idx]);
    assign hit_done   = rst_n && (state_q == IDLE) && req && hit;
    assign wb_done    = rst_n && (state_q == WRITEBACK) && mem_ready_D;
    assign fill_done  = rst_n && (state_q == ALLOCATE) && mem_ready_D;
    assign hit_line   = hit_way ? data_q[1][set_idx] : data_q[0][set_idx];

    // State register and latched victim way
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    // Next-state and memory-side outputs; reset forces every output quiet
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        DCACHE_stall = 1'b0;
        mem_read_D   = 1'b0;
        mem_write_D  = 1'b0;
        mem_addr_D   = DCACHE_addr[29:2];
        mem_wdata_D  = '0;
        if (!rst_n) begin
            mem_addr_D = '0;
            state_d    = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && !hit) begin
                        DCACHE_stall = 1'b1;
                        victim_d     = victim_sel;
                        state_d      = (valid_q[victim_sel][set_idx] && dirty_q[victim_sel][set_idx])
                                       ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    DCACHE_stall = 1'b1;
                    mem_write_D  = 1'b1;
                    mem_addr_D   = {tag_q[victim_q][set_idx], set_idx};
                    mem_wdata_D  = data_q[victim_q][set_idx];
                    if (mem_ready_D) state_d = ALLOCATE;
                end
                ALLOCATE: begin
                    DCACHE_stall = 1'b1;
                    mem_read_D   = 1'b1;
                    if (mem_ready_D) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Read data comes straight from the hitting line, zero otherwise
    always_comb begin
        DCACHE_rdata = '0;
        if (rst_n && (state_q == IDLE) && DCACHE_ren && hit)
            DCACHE_rdata = hit_line[{word_off, 5'b0} +: 32];
    end

    // Line status bits: valid, dirty and per-set LRU
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[0][s] <= 1'b0;
                valid_q[1][s] <= 1'b0;
                dirty_q[0][s] <= 1'b0;
                dirty_q[1][s] <= 1'b0;
                lru_q[s]      <= 1'b0;
            end
        end else begin
            if (hit_done) begin
                lru_q[set_idx] <= ~hit_way;
                if (DCACHE_wen) dirty_q[hit_way][set_idx] <= 1'b1;
            end
            if (wb_done) dirty_q[victim_q][set_idx] <= 1'b0;
            if (fill_done) begin
                valid_q[victim_q][set_idx] <= 1'b1;
                dirty_q[victim_q][set_idx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays: refill on allocate, word merge on write hit
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (hit_done && DCACHE_wen)
                data_q[hit_way][set_idx][{word_off, 5'b0} +: 32] <= DCACHE_wdata;
            if (fill_done) begin
                data_q[victim_q][set_idx] <= mem_rdata_D;
                tag_q[victim_q][set_idx]  <= addr_tag;
            end
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic miss_start;
    logic refilled_q;

    assign miss_start = rst_n && (state_q == IDLE) && req && !hit;

    // Hit/miss counters; the hit that finishes a refilled access is not a hit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            refilled_q <= 1'b0;
        end else begin
            if (miss_start) miss_cnt <= miss_cnt + 32'd1;
            if (fill_done) refilled_q <= 1'b1;
            if (hit_done) begin
                if (!refilled_q) hit_cnt <= hit_cnt + 32'd1;
                refilled_q <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_d_cache_2way_param.sv
// tb_d_cache_2way_param: self-checking bench for d_cache_2way_param
// (NUM_SETS=4). A timestamp-based cache model and a sparse backing memory
// predict every memory transaction and every read value.
module tb_d_cache_2way_param;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         DCACHE_ren, DCACHE_wen;
    logic [29:0]  DCACHE_addr;
    logic [31:0]  DCACHE_wdata;
    logic         DCACHE_stall;
    logic [31:0]  DCACHE_rdata;
    logic         mem_read_D, mem_write_D;
    logic [27:0]  mem_addr_D;
    logic [127:0] mem_wdata_D;
    logic [127:0] mem_rdata_D;
    logic         mem_ready_D;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    d_cache_2way_param #(.NUM_SETS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .DCACHE_ren(DCACHE_ren), .DCACHE_wen(DCACHE_wen),
        .DCACHE_addr(DCACHE_addr), .DCACHE_wdata(DCACHE_wdata),
        .DCACHE_stall(DCACHE_stall), .DCACHE_rdata(DCACHE_rdata),
        .mem_read_D(mem_read_D), .mem_write_D(mem_write_D),
        .mem_addr_D(mem_addr_D), .mem_wdata_D(mem_wdata_D),
        .mem_rdata_D(mem_rdata_D), .mem_ready_D(mem_ready_D)
`ifdef DCACHE_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: per-way validity, tag, dirty flag, contents and the
    // time of last use; the victim is the least recently used valid way.
    bit           m_valid [2][4];
    bit           m_dirty [2][4];
    logic [25:0]  m_tag   [2][4];
    logic [127:0] m_line  [2][4];
    longint       m_used  [2][4];
    longint       tick = 0;
    logic [127:0] bmem [logic [27:0]];
    int           exp_hits = 0, exp_misses = 0;

    // Observations of the last access, for the directed scenarios
    bit           last_miss, last_wb;
    logic [27:0]  last_wb_addr, last_fill_addr;
    logic [127:0] last_wb_data;
    logic [31:0]  last_rdata;

    function automatic logic [127:0] mem_block(input logic [27:0] b);
        logic [127:0] v;
        if (bmem.exists(b)) return bmem[b];
        for (int i = 0; i < 4; i++) v[i*32 +: 32] = {b, i[1:0], 2'b01} ^ 32'h5A5A_0000;
        return v;
    endfunction

    function automatic void model_reset();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 4; s++) begin
                m_valid[w][s] = 0;
                m_dirty[w][s] = 0;
                m_used[w][s]  = 0;
            end
        exp_hits   = 0;
        exp_misses = 0;
    endfunction

    task automatic go_idle();
        @(negedge clk);
        DCACHE_ren = 1'b0;
        DCACHE_wen = 1'b0;
        mem_ready_D = 1'b0;
    endtask

    // One processor access from request to completion, checked cycle by cycle
    task automatic do_access(input bit wr, input bit rd, input logic [29:0] a, input logic [31:0] wd);
        logic [1:0]   s = a[3:2];
        logic [25:0]  t = a[29:4];
        logic [27:0]  fa = a[29:2];
        logic [127:0] fdata;
        int           hw = -1;
        int           v, dly;
        bit           refilled = 0;
        for (int w = 0; w < 2; w++)
            if (hw < 0 && m_valid[w][s] && m_tag[w][s] == t) hw = w;
        last_miss = (hw < 0);
        last_wb   = 0;
        @(negedge clk);
        DCACHE_ren = rd; DCACHE_wen = wr; DCACHE_addr = a; DCACHE_wdata = wd;
        mem_ready_D = 1'b0;
        #1;
        if (hw < 0) begin
            exp_misses++;
            refilled = 1;
            if (!m_valid[0][s]) v = 0;
            else if (!m_valid[1][s]) v = 1;
            else v = (m_used[0][s] <= m_used[1][s]) ? 0 : 1;
            checks++;
            if ({DCACHE_stall, mem_read_D, mem_write_D} !== 3'b100) begin
                failures++;
                $display("[TB] FAIL miss_idle addr=%h stall/rd/wr=%b required 100", a, {DCACHE_stall, mem_read_D, mem_write_D});
            end
            @(posedge clk); @(negedge clk); #1;
            if (m_valid[v][s] && m_dirty[v][s]) begin
                last_wb = 1;
                last_wb_addr = {m_tag[v][s], s};
                last_wb_data = m_line[v][s];
                dly = $urandom_range(0, 2);
                for (int i = 0; i <= dly; i++) begin
                    checks++;
                    if ({DCACHE_stall, mem_read_D, mem_write_D, mem_addr_D} !== {3'b101, last_wb_addr}) begin
                        failures++;
                        $display("[TB] FAIL writeback_req addr=%h stall/rd/wr=%b mem_addr=%h required 101 %h",
                                 a, {DCACHE_stall, mem_read_D, mem_write_D}, mem_addr_D, last_wb_addr);
                    end
                    checks++;
                    if (mem_wdata_D !== last_wb_data) begin
                        failures++;
                        $display("[TB] FAIL writeback_data got=%h required %h", mem_wdata_D, last_wb_data);
                    end
                    mem_ready_D = (i == dly);
                    @(posedge clk); @(negedge clk);
                    mem_ready_D = 1'b0;
                    #1;
                end
                bmem[last_wb_addr] = last_wb_data;
                m_dirty[v][s] = 0;
            end
            fdata = mem_block(fa);
            last_fill_addr = fa;
            dly = $urandom_range(0, 2);
            for (int i = 0; i <= dly; i++) begin
                checks++;
                if ({DCACHE_stall, mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D} !== {3'b110, fa, 128'd0}) begin
                    failures++;
                    $display("[TB] FAIL allocate_req addr=%h stall/rd/wr=%b mem_addr=%h wdata_zero=%b required 110 %h",
                             a, {DCACHE_stall, mem_read_D, mem_write_D}, mem_addr_D, (mem_wdata_D == '0), fa);
                end
                mem_ready_D = (i == dly);
                mem_rdata_D = (i == dly) ? fdata : {4{$urandom()}};
                @(posedge clk); @(negedge clk);
                mem_ready_D = 1'b0;
                #1;
            end
            m_valid[v][s] = 1; m_dirty[v][s] = 0; m_tag[v][s] = t; m_line[v][s] = fdata;
            hw = v;
        end
        if (!refilled) exp_hits++;
        checks++;
        if ({DCACHE_stall, mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D} !== {3'b000, fa, 128'd0}) begin
            failures++;
            $display("[TB] FAIL hit_cycle addr=%h stall/rd/wr=%b mem_addr=%h required 000 %h",
                     a, {DCACHE_stall, mem_read_D, mem_write_D}, mem_addr_D, fa);
        end
        last_rdata = DCACHE_rdata;
        if (rd && !wr) begin
            checks++;
            if (DCACHE_rdata !== m_line[hw][s][int'(a[1:0])*32 +: 32]) begin
                failures++;
                $display("[TB] FAIL read_data addr=%h got=%h required %h", a, DCACHE_rdata, m_line[hw][s][int'(a[1:0])*32 +: 32]);
            end
        end
        tick++;
        m_used[hw][s] = tick;
        if (wr) begin
            m_line[hw][s][int'(a[1:0])*32 +: 32] = wd;
            m_dirty[hw][s] = 1;
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        DCACHE_ren = 1'b1; DCACHE_wen = 1'b0;
        DCACHE_addr = 30'h3FFF_FFF5; DCACHE_wdata = $urandom();
        mem_ready_D = 1'b1; mem_rdata_D = {4{$urandom()}};
        @(posedge clk); @(negedge clk); #1;
        checks++;
        if ({DCACHE_stall, mem_read_D, mem_write_D, DCACHE_rdata, mem_addr_D, mem_wdata_D} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs stall/rd/wr=%b rdata=%h mem_addr=%h required all zero",
                     {DCACHE_stall, mem_read_D, mem_write_D}, DCACHE_rdata, mem_addr_D);
        end
`ifdef DCACHE_PERF_CNT_EN
        checks++;
        if ({hit_cnt, miss_cnt} !== 64'd0) begin
            failures++;
            $display("[TB] FAIL reset_counters hit=%0d miss=%0d required 0 0", hit_cnt, miss_cnt);
        end
`endif
        rst_n = 1'b1;
        DCACHE_ren = 1'b0;
        mem_ready_D = 1'b0;
        model_reset();
    endtask

    task automatic test_directed_fill_and_evict();
        bmem[28'h4] = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        do_access(0, 1, 30'h10, 32'h0);
        checks++;
        if ({last_miss, last_fill_addr, last_rdata} !== {1'b1, 28'h4, 32'hA0}) begin
            failures++;
            $display("[TB] FAIL cold_read miss=%b fill=%h rdata=%h required 1 4 a0", last_miss, last_fill_addr, last_rdata);
        end
        do_access(1, 0, 30'h11, 32'hDEADBEEF);
        checks++;
        if (last_miss !== 1'b0) begin
            failures++;
            $display("[TB] FAIL write_hit miss=%b required 0", last_miss);
        end
        do_access(0, 1, 30'h11, 32'h0);
        checks++;
        if (last_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL read_after_write got=%h required deadbeef", last_rdata);
        end
`ifdef DCACHE_PERF_CNT_EN
        go_idle();
        checks++;
        if ({miss_cnt, hit_cnt} !== {32'd1, 32'd2}) begin
            failures++;
            $display("[TB] FAIL perf_counts miss=%0d hit=%0d required 1 2", miss_cnt, hit_cnt);
        end
`endif
        do_access(0, 1, 30'h20, 32'h0);
        do_access(0, 1, 30'h20, 32'h0);
        do_access(0, 1, 30'h30, 32'h0);
        checks++;
        if ({last_wb, last_wb_addr, last_wb_data[63:32], last_fill_addr} !== {1'b1, 28'h4, 32'hDEADBEEF, 28'hC}) begin
            failures++;
            $display("[TB] FAIL dirty_evict wb=%b wb_addr=%h wb_word1=%h fill=%h required 1 4 deadbeef c",
                     last_wb, last_wb_addr, last_wb_data[63:32], last_fill_addr);
        end
    endtask

    task automatic test_clean_evict();
        test_reset();
        do_access(0, 1, 30'h10, 32'h0);
        do_access(0, 1, 30'h20, 32'h0);
        do_access(0, 1, 30'h30, 32'h0);
        checks++;
        if ({last_miss, last_wb, last_fill_addr} !== {2'b10, 28'hC}) begin
            failures++;
            $display("[TB] FAIL clean_evict miss=%b wb=%b fill=%h required 1 0 c", last_miss, last_wb, last_fill_addr);
        end
    endtask

    task automatic test_reset_during_allocate();
        test_reset();
        @(negedge clk);
        DCACHE_ren = 1'b1; DCACHE_wen = 1'b0; DCACHE_addr = 30'h10;
        @(posedge clk); @(negedge clk); #1;
        checks++;
        if ({mem_read_D, mem_addr_D} !== {1'b1, 28'h4}) begin
            failures++;
            $display("[TB] FAIL alloc_before_reset rd=%b addr=%h required 1 4", mem_read_D, mem_addr_D);
        end
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        checks++;
        if ({DCACHE_stall, mem_read_D, mem_write_D} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL alloc_abandon stall/rd/wr=%b required 000", {DCACHE_stall, mem_read_D, mem_write_D});
        end
        rst_n = 1'b1;
        DCACHE_ren = 1'b0;
        model_reset();
        do_access(0, 1, 30'h10, 32'h0);
        checks++;
        if ({last_miss, last_fill_addr} !== {1'b1, 28'h4}) begin
            failures++;
            $display("[TB] FAIL miss_after_reset miss=%b fill=%h required 1 4", last_miss, last_fill_addr);
        end
    endtask

    task automatic test_idle_noop();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            DCACHE_ren = 1'b0; DCACHE_wen = 1'b0;
            DCACHE_addr = $urandom(); DCACHE_wdata = $urandom();
            mem_ready_D = 1'b1;
            #1;
            checks++;
            if ({DCACHE_stall, mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D} !== {3'b000, DCACHE_addr[29:2], 128'd0}) begin
                failures++;
                $display("[TB] FAIL idle_noop stall/rd/wr=%b mem_addr=%h required 000 %h",
                         {DCACHE_stall, mem_read_D, mem_write_D}, mem_addr_D, DCACHE_addr[29:2]);
            end
        end
        mem_ready_D = 1'b0;
    endtask

    task automatic test_random_traffic();
        logic [29:0] a;
        int op;
        test_reset();
        for (int n = 0; n < 250; n++) begin
            a = {$urandom_range(0, 3), 2'(n) ^ 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            a[29:6] = 24'($urandom_range(0, 2));
            op = $urandom_range(0, 9);
            if (op < 5) do_access(0, 1, a, 32'h0);
            else if (op < 9) do_access(1, 0, a, $urandom());
            else do_access(1, 1, a, $urandom());
            if (n % 50 == 0) test_idle_noop();
        end
`ifdef DCACHE_PERF_CNT_EN
        go_idle();
        checks++;
        if ({hit_cnt, miss_cnt} !== {32'(exp_hits), 32'(exp_misses)}) begin
            failures++;
            $display("[TB] FAIL random_counters hit=%0d miss=%0d required %0d %0d", hit_cnt, miss_cnt, exp_hits, exp_misses);
        end
`endif
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        DCACHE_ren = 1'b0; DCACHE_wen = 1'b0;
        DCACHE_addr = '0; DCACHE_wdata = '0;
        mem_rdata_D = '0; mem_ready_D = 1'b0;
        test_reset();
        test_directed_fill_and_evict();
        test_clean_evict();
        test_reset_during_allocate();
        test_idle_noop();
        test_random_traffic();
        go_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
